// File: rtl/seq_mult4_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult4_pkg;

  // Default operand width; the multiplier is also exercised at 8 bits.
  localparam int DEFAULT_W = 4;

  // Controller states: wait for a request, iterate W shift-add steps, announce result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult4_if.sv
// Request/result bundle between a requester (master) and the multiplier (slave).
interface seq_mult4_if
  import seq_mult4_pkg::*;
#(
  parameter int W = DEFAULT_W
) ();

  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_mult4_nibble_adder.sv
// W-bit combinational ripple-carry adder used for each shift-add step.
module nibble_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
  output logic [W-1:0] S,
  output logic         Co
);

  logic [W:0] w_c;

  assign w_c[0] = Ci;
  assign Co     = w_c[W];

  // One full adder per bit, carry rippling from bit 0 upward.
  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign S[gi]       = A[gi] ^ B[gi] ^ w_c[gi];
    assign w_c[gi + 1] = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
  end

endmodule

// File: rtl/seq_mult4.sv
// Sequential unsigned multiplier: W shift-add steps, fixed latency, registered product.
module seq_mult4
  import seq_mult4_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult4_if.slave bus
);

  // Counter holds 0..W so the final increment never wraps.
  localparam int CW = $clog2(W + 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_m;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_product;

  logic [W-1:0]   w_addend;
  logic [W-1:0]   w_sum;
  logic           w_co;
  logic [W-1:0]   w_acc_step;
  logic [W-1:0]   w_q_step;
  logic           w_last;

  // Add M only when the current multiplier LSB is set.
  assign w_addend = r_q[0] ? r_m : '0;

  nibble_adder #(.W(W)) u_adder (
    .A  (r_acc),
    .B  (w_addend),
    .Ci (1'b0),
    .S  (w_sum),
    .Co (w_co)
  );

  // Shift {C,SUM,Q} right by one: the carry re-enters at the top so none is lost.
  assign w_acc_step = {w_co, w_sum[W-1:1]};
  assign w_q_step   = {w_sum[0], r_q[W-1:1]};
  assign w_last     = (r_cnt == CW'(W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:                   w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state; busy and done are mutually exclusive.
  always_comb begin
    bus.busy = (r_state == RUN);
    bus.done = (r_state == DONE);
  end

  // Operand capture, shift-add iteration and product update on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_m   <= bus.a;
            r_q   <= bus.b;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_acc <= w_acc_step;
          r_q   <= w_q_step;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_product <= {w_acc_step, w_q_step};
        end
        default: ;
      endcase
    end
  end

  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mult4.sv
// Directed self-checking bench for seq_mult4 at W=4 and W=8.
module tb_seq_mult4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_mult4_if #(.W(4)) m4 ();
  seq_mult4_if #(.W(8)) m8 ();

  seq_mult4 #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(m4));
  seq_mult4 #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(m8));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One W=4 operation from IDLE: checks latency, busy length, product, single pulse.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
    int lat;
    int busy_cnt;
    m4.start = 1'b1;
    m4.a = a;
    m4.b = b;
    @(negedge clk);
    m4.start = 1'b0;
    lat = 0;
    busy_cnt = m4.busy ? 1 : 0;
    while (!m4.done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (m4.busy) busy_cnt++;
    end
    check({tag, " latency"}, 16'(lat), 16'd4);
    check({tag, " busy cycles"}, 16'(busy_cnt), 16'd4);
    check({tag, " busy at done"}, 16'(m4.busy), 16'd0);
    check({tag, " product"}, 16'(m4.product), 16'(exp));
    @(negedge clk);
    check({tag, " done single"}, 16'(m4.done), 16'd0);
    $display("op W=4 %s: a=0x%0h b=0x%0h product=0x%0h latency=%0d", tag, a, b, m4.product, lat);
  endtask

  initial begin
    int lat;
    int ndone;
    int last;
    m4.start = 1'b0; m4.a = '0; m4.b = '0;
    m8.start = 1'b0; m8.a = '0; m8.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 16'(m4.busy), 16'd0);
    check("reset done", 16'(m4.done), 16'd0);
    check("reset product", 16'(m4.product), 16'd0);
    check("reset product w8", 16'(m8.product), 16'd0);
    $display("reset: busy=%0d done=%0d product=0x%0h", m4.busy, m4.done, m4.product);

    // First edge with rst low accepts the request.
    rst = 1'b0;
    op4(4'h0, 4'h0, 8'h00, "zero");
    op4(4'hF, 4'hF, 8'hE1, "F*F");
    op4(4'h9, 4'hD, 8'h75, "9*D");
    op4(4'h5, 4'h3, 8'h0F, "5*3");

    // Operand and start changes during RUN must not disturb the result.
    m4.start = 1'b1; m4.a = 4'h7; m4.b = 4'h6;
    @(negedge clk);
    m4.a = 4'hF; m4.b = 4'hF;
    lat = 0;
    while (!m4.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    m4.start = 1'b0;
    check("ignore latency", 16'(lat), 16'd4);
    check("ignore product", 16'(m4.product), 16'h002A);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m4.done) ndone++;
    end
    check("ignore extra done", 16'(ndone), 16'd0);
    $display("op W=4 ignore: product=0x%0h extra_done=%0d", m4.product, ndone);

    // Start held high: a new result every W+2 cycles.
    m4.start = 1'b1; m4.a = 4'h3; m4.b = 4'h4;
    ndone = 0;
    last = 0;
    for (int c = 0; c < 40 && ndone < 3; c++) begin
      @(negedge clk);
      if (m4.done) begin
        check("held product", 16'(m4.product), 16'h000C);
        if (ndone > 0) check("held period", 16'(c - last), 16'd6);
        $display("op W=4 held: pulse %0d at cycle %0d product=0x%0h", ndone, c, m4.product);
        last = c;
        ndone++;
        if (ndone == 3) m4.start = 1'b0;
      end
    end
    check("held pulses", 16'(ndone), 16'd3);
    @(negedge clk);
    check("held idle busy", 16'(m4.busy), 16'd0);

    // Reset on the second RUN cycle aborts with no done and clears product.
    m4.start = 1'b1; m4.a = 4'hF; m4.b = 4'hF;
    @(negedge clk);
    m4.start = 1'b0;
    @(negedge clk);
    check("abort busy before rst", 16'(m4.busy), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 16'(m4.busy), 16'd0);
    check("abort done", 16'(m4.done), 16'd0);
    check("abort product", 16'(m4.product), 16'h0000);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m4.done) ndone++;
    end
    check("abort no done", 16'(ndone), 16'd0);
    $display("abort: busy=%0d product=0x%0h late_done=%0d", m4.busy, m4.product, ndone);
    op4(4'h2, 4'h3, 8'h06, "2*3 after abort");

    // W=8 full-range operand.
    m8.start = 1'b1; m8.a = 8'hFF; m8.b = 8'hFF;
    @(negedge clk);
    m8.start = 1'b0;
    lat = 0;
    while (!m8.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("w8 latency", 16'(lat), 16'd8);
    check("w8 product", m8.product, 16'hFE01);
    check("w8 busy at done", 16'(m8.busy), 16'd0);
    $display("op W=8: a=0xff b=0xff product=0x%0h latency=%0d", m8.product, lat);
    @(negedge clk);
    check("w8 done single", 16'(m8.done), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
